// File: rtl/mont_mul_pipe_if.sv
// mont_mul_pipe_if: operand-in / product-out handshake bundle.
// Range-check signals exist only with MONT_MUL_RANGE_CHECK_EN.
interface mont_mul_pipe_if #(
    parameter int WIDTH = 16,
    parameter int N     = 256
);
    localparam int IW = $clog2(N);

    logic                      in_valid;
    logic                      in_ready;
    logic signed [WIDTH-1:0]   in_a;
    logic signed [WIDTH-1:0]   in_b;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [2*WIDTH-1:0] out_prod;
    logic                      out_last;
    logic [IW-1:0]             out_idx;
`ifdef MONT_MUL_RANGE_CHECK_EN
    logic                      out_range_err;
    logic                      range_err_sticky;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_prod, out_last, out_idx,
        input  out_range_err, range_err_sticky
    );
    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_prod, out_last, out_idx,
        output out_range_err, range_err_sticky
    );
`else
    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_prod, out_last, out_idx
    );
    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_prod, out_last, out_idx
    );
`endif
endinterface

// File: rtl/mont_mul_pipe.sv
// mont_mul_pipe: 2-stage signed WIDTHxWIDTH multiplier feeding the Montgomery reducer.
// Optional MONT_MUL_RANGE_CHECK_EN adds out_range_err / range_err_sticky.
module mont_mul_pipe #(
    parameter int WIDTH   = 16,
    parameter int N       = 256,
    parameter int KYBER_Q = 3329
) (
    input logic           clk,
    input logic           rst,
    mont_mul_pipe_if.slave bus
);
    localparam int IW = $clog2(N);
    localparam int PW = 2 * WIDTH;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    logic                    s1_valid;
    logic signed [WIDTH-1:0] s1_a;
    logic signed [WIDTH-1:0] s1_b;
    logic signed [PW-1:0]    ext_a;
    logic signed [PW-1:0]    ext_b;
    logic signed [PW-1:0]    prod_c;
    logic signed [PW-1:0]    prod_q;
    logic                    out_valid_q;
    logic                    s2_adv;
    logic                    s1_adv;
    logic                    xfer;
    logic [IW-1:0]           cnt;

    assign s2_adv = !out_valid_q || bus.out_ready;
    assign s1_adv = !s1_valid || s2_adv;
    assign xfer   = out_valid_q && bus.out_ready;

    assign ext_a  = {{WIDTH{s1_a[WIDTH-1]}}, s1_a};
    assign ext_b  = {{WIDTH{s1_b[WIDTH-1]}}, s1_b};
    assign prod_c = ext_a * ext_b;

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = out_valid_q;
    assign bus.out_prod  = prod_q;
    assign bus.out_idx   = cnt;
    assign bus.out_last  = out_valid_q && (cnt == LAST);

    // Stage 1: capture the operand pair whenever the slot is free or drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_a <= bus.in_a;
                s1_b <= bus.in_b;
            end
        end
    end

    // Stage 2: register the full-precision product; holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            prod_q      <= '0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                prod_q <= prod_c;
            end
        end
    end

    // Coefficient index: advances only on an output transfer, wraps at N.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (xfer) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

`ifdef MONT_MUL_RANGE_CHECK_EN
    localparam logic signed [PW-1:0] RLIM = PW'(KYBER_Q) <<< (WIDTH - 1);

    logic range_c;
    logic err_q;
    logic sticky_q;

    assign range_c = (prod_c >= RLIM) || (prod_c <= -RLIM);
    assign bus.out_range_err    = err_q;
    assign bus.range_err_sticky = sticky_q;

    // Range flag travels with the product it describes.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (s2_adv && s1_valid) begin
            err_q <= range_c;
        end
    end

    // Sticky status: set by any transferred out-of-range product.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else if (xfer && err_q) begin
            sticky_q <= 1'b1;
        end
    end
`endif
endmodule
